// File: rtl/prange.sv
`default_nettype none
// ============================================================================
// Module   : prange
// Purpose  : Python-style range() generator streaming {index, value} pairs
//            through a small output FIFO with ready/valid handshake.
// Revision : 1.0  initial release
// ============================================================================
module prange #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                    _clock,
    input  logic                    _reset,
    input  logic                    _start,
    input  logic                    _ready,
    input  logic signed [WIDTH-1:0] base,
    input  logic signed [WIDTH-1:0] limit,
    input  logic signed [WIDTH-1:0] step,
    output logic                    _valid,
    output logic                    _done,
    output logic                    _error,
    output logic        [WIDTH-1:0] _0,
    output logic signed [WIDTH-1:0] _1
);

    localparam int c_AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic signed [WIDTH-1:0] r_value;
    logic signed [WIDTH-1:0] r_limit;
    logic signed [WIDTH-1:0] r_step;
    logic        [WIDTH-1:0] r_index;
    logic                    r_error;

    logic [WIDTH-1:0] r_mem_idx [DEPTH];
    logic [WIDTH-1:0] r_mem_val [DEPTH];
    logic [c_AW:0]    r_wptr;
    logic [c_AW:0]    r_rptr;

    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_can_push;
    logic             w_push;
    logic             w_load;
    logic             w_err_set;
    logic             w_step_zero;
    logic             w_in_range;
    logic [WIDTH:0]   w_sum;
    logic             w_ovf;

    assign w_empty    = (r_wptr == r_rptr);
    assign w_full     = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                        (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
    assign w_pop      = !w_empty && _ready;
    assign w_can_push = !w_full || w_pop;

    assign w_step_zero = (r_step == '0);
    assign w_in_range  = r_step[WIDTH-1] ? (r_value > r_limit) : (r_value < r_limit);

    // Sign-extended sum: a disagreement between the top two bits is a signed overflow.
    assign w_sum = {r_value[WIDTH-1], r_value} + {r_step[WIDTH-1], r_step};
    assign w_ovf = w_sum[WIDTH] ^ w_sum[WIDTH-1];

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_load      = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (_start) begin
                    w_load      = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_step_zero) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = DRAIN;
                end else if (!w_in_range) begin
                    w_state_nxt = DRAIN;
                end else if (w_can_push) begin
                    w_push = 1'b1;
                    // The element just pushed is the last representable one.
                    if (w_ovf) begin
                        w_state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (w_empty) begin
                    w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge _clock or negedge _reset) begin
        if (!_reset) begin
            r_state <= IDLE;
            r_value <= '0;
            r_limit <= '0;
            r_step  <= '0;
            r_index <= '0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_value <= base;
                r_limit <= limit;
                r_step  <= step;
                r_index <= '0;
                r_error <= 1'b0;
            end else begin
                if (w_push) begin
                    r_value <= w_sum[WIDTH-1:0];
                    r_index <= r_index + 1'b1;
                end
                if (w_err_set) begin
                    r_error <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge _clock or negedge _reset) begin
        if (!_reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_idx[i] <= '0;
                r_mem_val[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem_idx[r_wptr[c_AW-1:0]] <= r_index;
                r_mem_val[r_wptr[c_AW-1:0]] <= r_value;
                r_wptr                      <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    assign _valid = !w_empty;
    assign _done  = (r_state == DONE);
    assign _error = r_error;
    assign _0     = r_mem_idx[r_rptr[c_AW-1:0]];
    assign _1     = r_mem_val[r_rptr[c_AW-1:0]];

endmodule
`default_nettype wire

// File: doc/prange.md
PRANGE -- requirements
Module: prange

Interface
REQ-001 Parameter WIDTH, default 32: signed bit width of base, limit, step and both outputs.
REQ-002 Parameter DEPTH, default 2: output FIFO entries; power of two, >= 2.
REQ-003 _clock  in  1  single clock; all state changes on the rising edge.
REQ-004 _reset  in  1  reset, asynchronous and active-low.
REQ-005 _start  in  1  sampled high for one cycle to begin a run with base/limit/step.
REQ-006 _ready  in  1  consumer accepts the head output this cycle.
REQ-007 base, limit, step  in  WIDTH each  signed range arguments; sampled only on the start edge.
REQ-008 _valid  out  1  _0/_1 hold a valid element.
REQ-009 _done  out  1  run finished and all elements consumed.
REQ-010 _error  out  1  last run was rejected because step == 0.
REQ-011 _0  out  WIDTH  element index, from 0.
REQ-012 _1  out  WIDTH  signed element value.

Function
REQ-013 The block SHALL implement Python range semantics: emit base + i*step while the value < limit (step > 0) or the value > limit (step < 0).
REQ-014 The FSM SHALL have states IDLE, RUN, DRAIN and DONE; reset enters IDLE.
REQ-015 In IDLE or DONE, a start edge SHALL load base/limit/step, clear index, _done and _error, and enter RUN.
REQ-016 _start SHALL be ignored in RUN and DRAIN.
REQ-017 In RUN, each edge SHALL push {index, value} into the FIFO when the range condition holds and the FIFO can accept; it then advances value += step and index += 1.
REQ-018 The FIFO can accept when it is not full, or when a pop occurs on the same edge.
REQ-019 When the FIFO is full and no pop occurs, the generator SHALL stall, holding its value and index.
REQ-020 When the condition fails, RUN SHALL go to DRAIN with no push.
REQ-021 Next-value arithmetic SHALL use WIDTH+1 bits; signed overflow of value+step SHALL end the run after the current element, with no wrap-around element emitted.
REQ-022 step == 0 SHALL go RUN -> DRAIN with no push and set _error, which holds until the next accepted start.
REQ-023 DRAIN -> DONE SHALL occur on the first edge at which the FIFO is empty.
REQ-024 _done SHALL be 1 only in DONE.
REQ-025 _valid SHALL equal FIFO not-empty.
REQ-026 _0/_1 SHALL show the FIFO head.
REQ-027 A pop SHALL occur on an edge where _valid && _ready.
REQ-028 _0/_1 are don't-care while _valid = 0.
REQ-029 Latency: with _ready = 1, the first element SHALL be valid in the second cycle after the start edge, and the run SHALL sustain one element per cycle.
REQ-030 Element order SHALL be preserved, with no loss or duplication under any _ready pattern.
REQ-031 The index SHALL count modulo 2^WIDTH.

Reset
REQ-032 Asserting _reset (low) at any time, including mid-run, SHALL immediately force _valid = 0, _done = 0, _error = 0 and FIFO empty.
REQ-033 Reset SHALL also force IDLE state and index = 0, and discard any in-flight run.
REQ-034 _0/_1 SHALL reset to 0.
REQ-035 After deassertion, the block SHALL accept _start on the first rising edge.

Verification
REQ-036 Ascending range, WIDTH = 32, _ready = 1: (0, 10, 2) -> (0,0) (1,2) (2,4) (3,6) (4,8), then _done = 1 and _error = 0; repeat three back-to-back runs with identical output.
REQ-037 Descending and empty ranges: (10, 0, -3) -> (0,10) (1,7) (2,4) (3,1), then _done; (5, 5, 1) -> _valid never asserted and _done = 1 within 3 cycles of start.
REQ-038 Zero step: (0, 10, 0) -> no elements, _error = 1, _done = 1; the next start (0, 2, 1) clears _error and yields (0,0) (1,1).
REQ-039 Backpressure, DEPTH = 2: run (0, 10, 2), hold _ready = 0 for 6 cycles, then toggle it every cycle -> the FIFO fills and the generator stalls; the full sequence is received in order, with no duplicates.
REQ-040 Overflow, WIDTH = 8: (100, 127, 20) -> (0,100) (1,120), then _done, with no wrapped value (-116) emitted.
REQ-041 Reset mid-run: run (0, 100, 1), pull _reset low after 5 elements -> outputs clear immediately; a new start (0, 3, 1) yields (0,0) (1,1) (2,2).
